// File: rtl/e3digit_to_7seg.sv
// e3digit_to_7seg
//   Registered decoder from one excess-3 coded decimal digit to a
//   7-segment pattern plus decimal point. Invalid codes show a dash
//   (optionally with dp) and raise err.
// Parameters
//   ACTIVE_LOW   1 = invert all 8 seg bits (common-anode), 0 = active-high
//   DP_ON_ERROR  1 = light dp on invalid codes, 0 = dp always off
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active-low
//   digit  in   [3:0] XS-3 digit (d encoded as d+3)
//   seg    out  [7:0] {dp,g,f,e,d,c,b,a}, registered
//   err    out  registered invalid-code flag (never inverted)
module e3digit_to_7seg #(
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter bit DP_ON_ERROR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  output logic [7:0] seg,
  output logic       err
);

  logic [7:0] dec;
  logic       dec_err;
  logic [7:0] pol;

  // Active-high decode table; X/Z codes match no item and fall to default.
  always_comb begin
    dec     = '0;
    dec_err = 1'b0;
    case (digit)
      4'b0011: dec = 8'h3F;
      4'b0100: dec = 8'h06;
      4'b0101: dec = 8'h5B;
      4'b0110: dec = 8'h4F;
      4'b0111: dec = 8'h66;
      4'b1000: dec = 8'h6D;
      4'b1001: dec = 8'h7D;
      4'b1010: dec = 8'h07;
      4'b1011: dec = 8'h7F;
      4'b1100: dec = 8'h6F;
      default: begin
        dec     = {DP_ON_ERROR, 7'b100_0000};
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    pol = ACTIVE_LOW ? ~dec : dec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= {8{ACTIVE_LOW}};
      err <= 1'b0;
    end else begin
      seg <= pol;
      err <= dec_err;
    end
  end

endmodule

// File: tb/tb_e3digit_to_7seg.sv
module tb_e3digit_to_7seg;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic [7:0] seg0, seg1, seg2;
  logic       err0, err1, err2;

  int checks;
  int failures;

  // Lit segments per decimal digit, by segment letter.
  string pat [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  // Default: active-high, dp on error
  e3digit_to_7seg dut0 (
    .clk(clk), .rst_n(rst_n), .digit(digit), .seg(seg0), .err(err0)
  );
  // Common-anode
  e3digit_to_7seg #(.ACTIVE_LOW(1'b1), .DP_ON_ERROR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .digit(digit), .seg(seg1), .err(err1)
  );
  // No dp on error
  e3digit_to_7seg #(.ACTIVE_LOW(1'b0), .DP_ON_ERROR(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .digit(digit), .seg(seg2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_seg(bit rst, logic [3:0] code, bit al, bit dpe);
    logic [7:0] v;
    int d;
    string s;
    v = 8'h00;
    if (rst) begin
      d = int'(code) - 3;
      if (d >= 0 && d <= 9) begin
        s = pat[d];
        for (int i = 0; i < s.len(); i++) v[int'(s[i]) - 97] = 1'b1;
      end else begin
        v[6] = 1'b1;
        v[7] = dpe;
      end
    end
    return al ? ~v : v;
  endfunction

  function automatic logic model_err(bit rst, logic [3:0] code);
    return rst && !(code >= 4'd3 && code <= 4'd12);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then compare all instances to the model.
  task automatic step(input bit r, input logic [3:0] d);
    rst_n = r;
    digit = d;
    @(posedge clk);
    #1;
    chk("seg_default", seg0, model_seg(r, d, 1'b0, 1'b1));
    chk("seg_al",      seg1, model_seg(r, d, 1'b1, 1'b1));
    chk("seg_nodp",    seg2, model_seg(r, d, 1'b0, 1'b0));
    chk("err_default", {7'b0, err0}, {7'b0, model_err(r, d)});
    chk("err_al",      {7'b0, err1}, {7'b0, model_err(r, d)});
    chk("err_nodp",    {7'b0, err2}, {7'b0, model_err(r, d)});
  endtask

  initial begin
    logic [3:0] inv [6];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    digit    = 4'b0000;
    inv      = '{4'b0000, 4'b0001, 4'b0010, 4'b1101, 4'b1110, 4'b1111};

    // Reset with a valid digit present
    step(1'b0, 4'b0110);
    step(1'b0, 4'b0110);
    chk("rst_seg_ah", seg0, 8'h00);
    chk("rst_seg_al", seg1, 8'hFF);
    chk("rst_err",    {7'b0, err0}, 8'h00);

    // Valid sweep
    for (int c = 3; c <= 12; c++) step(1'b1, 4'(c));
    chk("sweep_last", seg0, 8'h6F);

    // Invalid codes
    for (int i = 0; i < 6; i++) begin
      step(1'b1, inv[i]);
      chk("inv_seg_dp",   seg0, 8'hC0);
      chk("inv_seg_nodp", seg2, 8'h40);
      chk("inv_err",      {7'b0, err0}, 8'h01);
    end

    // Latency
    step(1'b1, 4'b0011);
    chk("lat_n1", seg0, 8'h3F);
    digit = 4'b1100;
    #2;
    chk("lat_hold", seg0, 8'h3F);
    step(1'b1, 4'b1100);
    chk("lat_n2", seg0, 8'h6F);

    // Reset mid-stream
    step(1'b1, 4'b1011);
    step(1'b0, 4'b1011);
    chk("mid_rst_seg", seg0, 8'h00);
    chk("mid_rst_err", {7'b0, err0}, 8'h00);
    step(1'b1, 4'b1011);
    chk("mid_rel_seg", seg0, 8'h7F);

    // Active-low specifics
    step(1'b1, 4'b0011);
    chk("al_zero", seg1, 8'hC0);
    step(1'b1, 4'b1111);
    chk("al_inv",     seg1, 8'h3F);
    chk("al_inv_err", {7'b0, err1}, 8'h01);

    // Randomized
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(7) != 0), 4'($urandom_range(15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
